// File: rtl/lz_pkg.sv
// Shared types and helpers for the pipelined leading-zero counter.
// Latency: none (package only).
// Backpressure: none (package only).
package lz_pkg;

    localparam int LZ_BYTE_W = 8;
    localparam int LZ_CNT_W  = 3;

    // Per-byte encoding: z_bar=1 when the byte holds a set bit, cnt = zeros above it
    typedef struct packed {
        logic                z_bar;
        logic [LZ_CNT_W-1:0] cnt;
    } lz_byte_t;

    // Count width needed to represent 0..width inclusive
    function automatic int lz_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lz_byte.sv
// Combinational 8-bit leading-zero encoder producing {z_bar, cnt}.
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the enclosing pipeline stage decides when to capture.
module lz_byte
    import lz_pkg::*;
(
    input  logic [LZ_BYTE_W-1:0] byte_i,
    output lz_byte_t             enc_o
);

    // Scan from LSB upward so the highest set bit is the one that sticks
    always_comb begin
        enc_o.z_bar = |byte_i;
        enc_o.cnt   = '0;
        for (int i = 0; i < LZ_BYTE_W; i++) begin
            if (byte_i[i]) begin
                enc_o.cnt = LZ_CNT_W'(LZ_BYTE_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lz_count_pipe.sv
// Two-stage leading-zero counter (per-byte encode, then merge); LZC_NORM_EN adds a normalised-operand output.
// Latency: 2 cycles from input acceptance to o_valid, throughput 1 per cycle.
// Backpressure: both stages hold when i_ready=0; o_ready is combinational from i_ready, no skid buffer.
module lz_count_pipe
    import lz_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int TAG_W = 4,
    localparam int CW    = lz_cw(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CW-1:0]    o_zeros,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
`ifdef LZC_NORM_EN
    ,
    output logic [WIDTH-1:0] o_norm
`endif
);

    localparam int NB = WIDTH / LZ_BYTE_W;

    logic                 advance_s1;
    logic                 advance_s2;

    lz_byte_t [NB-1:0]    enc_d;
    lz_byte_t [NB-1:0]    s1_enc_q;
    logic                 s1_vld_q;
    logic [TAG_W-1:0]     s1_tag_q;

    logic [CW-1:0]        zeros_d;
    logic                 zero_d;
    logic [CW-1:0]        zeros_q;
    logic                 zero_q;
    logic                 valid_q;
    logic [TAG_W-1:0]     tag_q;

    // A stage may load when it is empty or its contents move on this edge
    assign advance_s2 = !valid_q || i_ready;
    assign advance_s1 = !s1_vld_q || advance_s2;
    assign o_ready    = advance_s1;

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_byte
            lz_byte u_byte (
                .byte_i (i_data[g*LZ_BYTE_W +: LZ_BYTE_W]),
                .enc_o  (enc_d[g])
            );
        end
    endgenerate

    // Stage 1: capture per-byte encodings and the tag of an accepted operand
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_q <= 1'b0;
            s1_enc_q <= '0;
            s1_tag_q <= '0;
        end else if (advance_s1) begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
                s1_enc_q <= enc_d;
                s1_tag_q <= i_tag;
            end
        end
    end

    // Priority merge: walk bytes from LSB upward so the most significant non-zero byte wins
    always_comb begin
        zeros_d = CW'(WIDTH);
        zero_d  = 1'b1;
        for (int j = 0; j < NB; j++) begin
            if (s1_enc_q[j].z_bar) begin
                zeros_d = (CW'(NB - 1 - j) << 3) + CW'(s1_enc_q[j].cnt);
                zero_d  = 1'b0;
            end
        end
    end

    // Stage 2: register the merged count; outputs hold while the result is unaccepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            zeros_q <= '0;
            zero_q  <= 1'b0;
            tag_q   <= '0;
        end else if (advance_s2) begin
            valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                zeros_q <= zeros_d;
                zero_q  <= zero_d;
                tag_q   <= s1_tag_q;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_zeros = zeros_q;
    assign o_zero  = zero_q;
    assign o_tag   = tag_q;

`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] s1_data_q;
    logic [WIDTH-1:0] norm_q;

    // Operand travels with its encodings so it can be shifted in stage 2
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_data_q <= '0;
        end else if (advance_s1 && i_valid) begin
            s1_data_q <= i_data;
        end
    end

    // Zero-fill shift; an all-zero operand naturally yields zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            norm_q <= '0;
        end else if (advance_s2 && s1_vld_q) begin
            norm_q <= s1_data_q << zeros_d;
        end
    end

    assign o_norm = norm_q;
`endif

endmodule

// File: tb/tb_lz_count_pipe.sv
module tb_lz_count_pipe;
    import lz_pkg::*;

    localparam int WIDTH = 64;
    localparam int TAG_W = 4;
    localparam int CW    = lz_cw(WIDTH);

    typedef struct {
        logic [CW-1:0]    zeros;
        logic             zero;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] norm;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic [TAG_W-1:0] i_tag = '0;
    logic             o_ready;
    logic             o_valid;
    logic [CW-1:0]    o_zeros;
    logic             o_zero;
    logic [TAG_W-1:0] o_tag;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] o_norm;
`endif

    int   errs = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lz_count_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_zeros (o_zeros),
        .o_zero  (o_zero),
        .o_tag   (o_tag)
`ifdef LZC_NORM_EN
        ,
        .o_norm  (o_norm)
`endif
    );

    // Bit-serial reference: count zeros from the MSB down to the first one
    function automatic int clz_ref(input logic [WIDTH-1:0] d);
        int n = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic exp_t make_exp(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
        exp_t e;
        int   n = clz_ref(d);
        e.zeros = CW'(n);
        e.zero  = (d == '0);
        e.tag   = t;
        e.norm  = (d == '0) ? '0 : (d << n);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) return '0;
        return v >> $urandom_range(0, WIDTH - 1);
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_zeros !== '0)   begin errs++; $display("FAIL rst_zeros: got %0d expected 0", o_zeros); end
        checks++; if (o_zero !== 1'b0)  begin errs++; $display("FAIL rst_zero: got %b expected 0", o_zero); end
        checks++; if (o_tag !== '0)     begin errs++; $display("FAIL rst_tag: got %0d expected 0", o_tag); end
`ifdef LZC_NORM_EN
        checks++; if (o_norm !== '0)    begin errs++; $display("FAIL rst_norm: got %h expected 0", o_norm); end
`endif
        rst_n   = 1'b1;
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
    endtask

    // Single operand with i_ready=1: checks acceptance, 2-cycle latency and value
    task automatic test_directed(input logic [WIDTH-1:0] d, input int exp_z, input logic exp_zero,
                                 input logic [TAG_W-1:0] tag);
        int               lat;
        logic [WIDTH-1:0] exp_norm;
        exp_norm = exp_zero ? '0 : (d << exp_z);
        @(negedge clk);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = d;
        i_tag   = tag;
        #1;
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL dir_accept: o_ready got %b expected 1", o_ready); end
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 2)                begin errs++; $display("FAIL dir_latency: got %0d expected 2", lat); end
        checks++; if (o_zeros !== CW'(exp_z))  begin errs++; $display("FAIL dir_zeros: data %h got %0d expected %0d", d, o_zeros, exp_z); end
        checks++; if (o_zero !== exp_zero)     begin errs++; $display("FAIL dir_zero: data %h got %b expected %b", d, o_zero, exp_zero); end
        checks++; if (o_tag !== tag)           begin errs++; $display("FAIL dir_tag: got %0d expected %0d", o_tag, tag); end
`ifdef LZC_NORM_EN
        checks++; if (o_norm !== exp_norm)     begin errs++; $display("FAIL dir_norm: got %h expected %h", o_norm, exp_norm); end
`endif
        @(negedge clk);
        checks++; if (o_valid !== 1'b0)        begin errs++; $display("FAIL dir_single: o_valid got %b expected 0", o_valid); end
    endtask

`ifdef LZC_NORM_EN
    task automatic test_norm();
        logic [WIDTH-1:0] d  = 64'h0000_0000_00F0_0000;
        logic [WIDTH-1:0] ex = 64'hF000_0000_0000_0000;
        @(negedge clk);
        i_ready = 1'b1; i_valid = 1'b1; i_data = d; i_tag = 4'd5;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_zeros !== CW'(40)) begin errs++; $display("FAIL norm_zeros: got %0d expected 40", o_zeros); end
        checks++; if (o_norm !== ex)       begin errs++; $display("FAIL norm_value: got %h expected %h", o_norm, ex); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ops[8];
        int   sent = 0, got = 0, first = -1, last = -1;
        exp_t e;
        for (int i = 0; i < 8; i++) ops[i] = rnd_op();
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            i_ready = 1'b1;
            i_valid = (sent < 8);
            i_data  = ops[sent % 8];
            i_tag   = TAG_W'(sent);
            #1;
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin errs++; $display("FAIL b2b_extra: unexpected result tag %0d", o_tag); end
                else begin
                    e = sb.pop_front();
                    if (o_zeros !== e.zeros || o_zero !== e.zero || o_tag !== e.tag) begin
                        errs++;
                        $display("FAIL b2b_result: got zeros=%0d zero=%b tag=%0d expected zeros=%0d zero=%b tag=%0d",
                                 o_zeros, o_zero, o_tag, e.zeros, e.zero, e.tag);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (i_valid) begin
                checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b expected 1", o_ready); end
                if (o_ready) begin
                    sb.push_back(make_exp(i_data, i_tag));
                    sent++;
                end
            end
        end
        checks++; if (got != 8)          begin errs++; $display("FAIL b2b_count: got %0d expected 8", got); end
        checks++; if (last - first != 7) begin errs++; $display("FAIL b2b_spacing: got %0d expected 7", last - first); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] ops[3];
        logic [CW-1:0]    hz = '0;
        logic [TAG_W-1:0] ht = '0;
        int   sent = 0, got = 0;
        exp_t e;
        ops[0] = 64'h0000_0000_0000_0F00;
        ops[1] = 64'h0020_0000_0000_0000;
        ops[2] = 64'h0000_0000_0000_0000;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            i_ready = (cyc >= 7);
            i_valid = (sent < 3);
            i_data  = ops[sent % 3];
            i_tag   = TAG_W'(sent + 1);
            #1;
            if (cyc == 2) begin
                hz = o_zeros;
                ht = o_tag;
                checks++; if (sent != 2)        begin errs++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
            end
            if (cyc >= 2 && cyc <= 6) begin
                checks++; if (o_ready !== 1'b0) begin errs++; $display("FAIL bp_ready: cycle %0d got %b expected 0", cyc, o_ready); end
                checks++; if (o_valid !== 1'b1) begin errs++; $display("FAIL bp_valid: cycle %0d got %b expected 1", cyc, o_valid); end
            end
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if (o_zeros !== hz || o_tag !== ht) begin
                    errs++;
                    $display("FAIL bp_hold: cycle %0d got zeros=%0d tag=%0d expected zeros=%0d tag=%0d", cyc, o_zeros, o_tag, hz, ht);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin errs++; $display("FAIL bp_extra: unexpected result tag %0d", o_tag); end
                else begin
                    e = sb.pop_front();
                    if (o_zeros !== e.zeros || o_zero !== e.zero || o_tag !== e.tag) begin
                        errs++;
                        $display("FAIL bp_result: got zeros=%0d zero=%b tag=%0d expected zeros=%0d zero=%b tag=%0d",
                                 o_zeros, o_zero, o_tag, e.zeros, e.zero, e.tag);
                    end
                end
                got++;
            end
            if (i_valid && o_ready) begin
                sb.push_back(make_exp(i_data, i_tag));
                sent++;
            end
        end
        checks++; if (got != 3 || sb.size() != 0) begin errs++; $display("FAIL bp_drain: got %0d results, %0d left, expected 3 and 0", got, sb.size()); end
    endtask

    task automatic test_reset_midflight();
        int spurious = 0;
        @(negedge clk);
        i_ready = 1'b0; i_valid = 1'b1; i_data = 64'h0000_0000_1000_0000; i_tag = 4'd9;
        @(negedge clk);
        i_data = 64'h0100_0000_0000_0000; i_tag = 4'd10;
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b1) begin errs++; $display("FAIL mid_inflight: o_valid got %b expected 1", o_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_tag !== '0)     begin errs++; $display("FAIL mid_rst_tag: got %0d expected 0", o_tag); end
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errs++; $display("FAIL mid_dropped: got %0d stale results expected 0", spurious); end
        test_directed(64'h0000_0000_0000_0080, 56, 1'b0, 4'd3);
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic [WIDTH-1:0] ops[N];
        int   sent = 0, got = 0;
        exp_t e;
        for (int i = 0; i < N; i++) ops[i] = rnd_op();
        for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
            @(negedge clk);
            i_ready = ($urandom_range(0, 9) < 7);
            i_valid = (sent < N) && ($urandom_range(0, 3) != 0);
            i_data  = ops[sent % N];
            i_tag   = TAG_W'(sent);
            #1;
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin errs++; $display("FAIL rnd_extra: unexpected result tag %0d", o_tag); end
                else begin
                    e = sb.pop_front();
                    if (o_zeros !== e.zeros || o_zero !== e.zero || o_tag !== e.tag) begin
                        errs++;
                        $display("FAIL rnd_result: got zeros=%0d zero=%b tag=%0d expected zeros=%0d zero=%b tag=%0d",
                                 o_zeros, o_zero, o_tag, e.zeros, e.zero, e.tag);
                    end
`ifdef LZC_NORM_EN
                    checks++;
                    if (o_norm !== e.norm) begin errs++; $display("FAIL rnd_norm: got %h expected %h", o_norm, e.norm); end
`endif
                end
                got++;
            end
            if (i_valid && o_ready) begin
                sb.push_back(make_exp(i_data, i_tag));
                sent++;
            end
        end
        checks++; if (got != N || sb.size() != 0) begin errs++; $display("FAIL rnd_count: got %0d results, %0d left, expected %0d and 0", got, sb.size(), N); end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed(64'h8000_0000_0000_0000, 0,  1'b0, 4'd1);
        test_directed(64'h0000_0000_0000_0001, 63, 1'b0, 4'd2);
        test_directed(64'h0000_0000_0000_0000, 64, 1'b1, 4'd3);
        test_directed(64'h0000_0100_0000_0000, 23, 1'b0, 4'd4);
`ifdef LZC_NORM_EN
        test_norm();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
